uart_rx_byte: RTL and testbench
===============================

Name: uart_rx_byte

Overview:
- Serial receiver that recovers 8N1 bytes from the uart_rx pin of led_uart_soc.
- Delivers each byte to the SoC's memory-mapped UART read register through a valid/ready holding stage.
- Sits directly between the board pin and the SoC bus-side UART register.
- Reports framing errors and overruns as single-cycle pulses for the status register.

Parameters:
- CLKS_PER_BIT, 104: clock cycles per bit period (12 MHz / 115200). Legal range 4..65535.
- SYNC_STAGES, 2: flops in the rx input synchronizer. Legal range 2..3.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- uart_rx  input  1  asynchronous serial line; idles high
- rx_data  output  8  received byte; valid only while rx_valid=1
- rx_valid  output  1  holding register contains an unread byte
- rx_ready  input  1  consumer accepts the byte when rx_valid && rx_ready at a clk edge
- frame_error  output  1  one-cycle pulse: stop bit sampled low
- overrun  output  1  one-cycle pulse: byte completed while the holding register was full and not being read
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset (sampled on a clk edge with reset=1):
  - state=IDLE; rx_data=8'h00; rx_valid=0; frame_error=0; overrun=0; busy=0.
  - Synchronizer flops preset to 1.
  - Bit counter and clock counter cleared.
  - Reset mid-frame abandons the frame; nothing is delivered and no error pulse is produced.
- Input path:
  - uart_rx passes through SYNC_STAGES flops, giving rx_s.
  - All decisions use rx_s only. Pin-to-rx_s latency is SYNC_STAGES cycles.
- Clock counter:
  - Width is $clog2(CLKS_PER_BIT).
  - Reloads on every state transition.
- IDLE:
  - rx_s=0 -> START; counter loaded to CLKS_PER_BIT/2 - 1 (integer division).
- START:
  - On counter expiry, sample rx_s at mid-start-bit.
  - 0 -> DATA, bit index=0, counter=CLKS_PER_BIT-1.
  - 1 -> IDLE (false start/glitch); no pulse.
- DATA:
  - Each expiry samples rx_s into shift[index]. LSB is received first.
  - After index 7 -> STOP, counter=CLKS_PER_BIT-1.
- STOP:
  - On expiry, sample rx_s.
  - 1 -> deliver the byte (see holding stage), then IDLE.
  - 0 -> frame_error pulses for exactly 1 cycle, byte discarded, then BREAK.
- BREAK:
  - Remain until rx_s=1, then IDLE.
  - A continuous low line yields exactly one frame_error per break.
- Holding stage (one entry):
  - Delivery cycle = the clk edge on which the stop bit is sampled high.
  - rx_valid and rx_data update on that edge, so they are visible the cycle after the stop-bit sample.
  - If rx_valid=0, or rx_valid && rx_ready in the same cycle: load the new byte, rx_valid=1, no overrun.
  - If rx_valid=1 && rx_ready=0: keep the old byte, drop the new one, overrun pulses for 1 cycle.
  - Accept without delivery: rx_valid && rx_ready clears rx_valid on the next edge; rx_data holds its last value.
- Timing:
  - Sample points fall at (n + 0.5)·CLKS_PER_BIT cycles after the synchronized falling edge, n=0..9, with ±1 cycle tolerance.
  - Back-to-back frames with zero idle time are received without loss: IDLE is re-entered before the next start edge.
- frame_error and overrun can never both pulse in the same cycle.

Decomposition:
- Shared package uart_pkg:
  - State encoding enum (IDLE, START, DATA, STOP, BREAK).
  - Constants DATA_BITS=8 and DEFAULT_CLKS_PER_BIT=104.
  - The package is reused by the matching transmitter.
- One sub-module: sync_bit (SYNC_STAGES-deep synchronizer with reset value parameter).
- Everything else stays inline.

Test Plan:
1. All directed tests use CLKS_PER_BIT=8, rx_ready held 1, and nominal bit timing.
   - Send 8'hA5 -> rx_valid pulses with rx_data=8'hA5.
   - Verify the pulse lands 1 cycle after the stop sample, about 76 cycles after the pin falling edge.
   - No error pulses.
2. False start: drive uart_rx low for 2 cycles, then high.
   - Require return to IDLE, no rx_valid, and busy low within 6 cycles.
3. Framing error: send 8'h3C with the stop bit low, then hold low for 30 cycles, then high.
   - Exactly one frame_error pulse; rx_valid stays 0.
   - Next frame 8'h55 is received correctly.
4. Overrun:
   - rx_ready=0; send 8'h11 then 8'h22 back-to-back -> rx_data=8'h11 retained, one overrun pulse.
   - Then rx_ready=1 for 1 cycle -> rx_valid clears.
   - Same sequence, but rx_ready=1 on exactly the delivery cycle of 8'h22 -> rx_data=8'h22, no overrun.
5. Reset mid-frame: assert reset during DATA bit 4 of 8'hF0.
   - All outputs at reset values; no rx_valid, no frame_error.
   - A following 8'h0F is received correctly.
6. Timing tolerance and throughput: stream 16 random bytes with bit period 7 and 9 cycles (about ±12%).
   - All bytes are delivered in order without errors.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants and the receiver/transmitter state encoding.
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 104;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_state_e;

endpackage

// File: rtl/uart_rx_byte_sync_bit.sv
// Multi-flop synchronizer for one asynchronous bit, with a selectable reset value.
module sync_bit #(
  parameter int   STAGES      = 2,
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // NOTE: non-blocking assignments make every stage capture its predecessor's old value, forming a real shift chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      ff <= {STAGES{RESET_VALUE}};
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver with mid-bit sampling, a one-entry valid/ready holding register,
// and single-cycle framing-error / overrun pulses.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_error,
  output logic       overrun,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic                 rx_s;
  uart_state_e          state, state_next;
  logic [CNT_W-1:0]     cnt, cnt_next;
  logic [IDX_W-1:0]     idx, idx_next;
  logic [DATA_BITS-1:0] shift, shift_next;
  logic                 expired;
  logic                 deliver;
  logic                 ferr_set;

  sync_bit #(
    .STAGES      (SYNC_STAGES),
    .RESET_VALUE (1'b1)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (uart_rx),
    .q     (rx_s)
  );

  assign expired = (cnt == '0);
  assign busy    = (state != IDLE);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idx_next   = idx;
    shift_next = shift;
    deliver    = 1'b0;
    ferr_set   = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          cnt_next   = CNT_HALF;
        end
      end
      START: begin
        if (!expired) begin
          cnt_next = cnt - CNT_W'(1);
        end else if (!rx_s) begin
          state_next = DATA;
          idx_next   = '0;
          cnt_next   = CNT_FULL;
        end else begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      end
      DATA: begin
        if (!expired) begin
          cnt_next = cnt - CNT_W'(1);
        end else begin
          shift_next[idx] = rx_s;
          cnt_next        = CNT_FULL;
          if (idx == IDX_LAST) begin
            state_next = STOP;
          end else begin
            idx_next = idx + IDX_W'(1);
          end
        end
      end
      STOP: begin
        if (!expired) begin
          cnt_next = cnt - CNT_W'(1);
        end else begin
          cnt_next = '0;
          if (rx_s) begin
            deliver    = 1'b1;
            state_next = IDLE;
          end else begin
            ferr_set   = 1'b1;
            state_next = BREAK;
          end
        end
      end
      BREAK: begin
        // Wait out a held-low line so a long break reports only one framing error.
        if (rx_s) begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      rx_data     <= 8'h00;
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      idx         <= idx_next;
      frame_error <= ferr_set;
      overrun     <= deliver && rx_valid && !rx_ready;
      if (deliver && (!rx_valid || rx_ready)) begin
        rx_data  <= shift;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  // NOTE: the shift register is left unreset; all eight bits are rewritten before any delivery.
  always_ff @(posedge clk) begin
    shift <= shift_next;
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Self-checking bench for uart_rx_byte: directed frames plus a jittered random byte stream.
module tb_uart_rx_byte;

  localparam int CPB  = 8;
  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       uart_rx;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_error;
  logic       overrun;
  logic       busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_rx_byte #(
    .CLKS_PER_BIT (CPB),
    .SYNC_STAGES  (SYNC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .uart_rx     (uart_rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_error (frame_error),
    .overrun     (overrun),
    .busy        (busy)
  );

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Observer: records accepted bytes and pulse counts away from the active edge.
  logic [7:0] got[$];
  int fe_cnt = 0, ov_cnt = 0, both_cnt = 0, last_acc_cyc = 0;
  bit busy_seen = 1'b0;

  always @(negedge clk) begin
    if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
      got.push_back(rx_data);
      last_acc_cyc = cyc;
    end
    if (frame_error === 1'b1) fe_cnt++;
    if (overrun === 1'b1) ov_cnt++;
    if (frame_error === 1'b1 && overrun === 1'b1) both_cnt++;
    if (busy === 1'b1) busy_seen = 1'b1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    got.delete();
    fe_cnt    = 0;
    ov_cnt    = 0;
    both_cnt  = 0;
    busy_seen = 1'b0;
  endtask

  function automatic logic [31:0] got_at(input int i);
    if (i < got.size()) return {24'h0, got[i]};
    return 32'hxxxx_xxxx;
  endfunction

  task automatic drive(input logic v, input int n);
    uart_rx = v;
    repeat (n) tick();
  endtask

  // Sends one 8N1 frame. With jitter, each bit lasts 7, 8 or 9 cycles while every
  // bit boundary stays within one cycle of its nominal position.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit jitter);
    logic [9:0] frame;
    int off, noff;
    frame = {stop_bit, b, 1'b0};
    off = 0;
    for (int i = 0; i < 10; i++) begin
      noff = off;
      if (jitter) begin
        noff = off + int'($urandom_range(2)) - 1;
        if (noff > 1) noff = 1;
        if (noff < -1) noff = -1;
      end
      drive(frame[i], CPB + noff - off);
      off = noff;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_data"}, rx_data, 8'h00);
    check({tag, "_rx_valid"}, rx_valid, 1'b0);
    check({tag, "_frame_error"}, frame_error, 1'b0);
    check({tag, "_overrun"}, overrun, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int start_cyc, lat;

    reset    = 1'b1;
    uart_rx  = 1'b1;
    rx_ready = 1'b1;
    repeat (3) tick();
    check_reset_outputs("reset");
    reset = 1'b0;
    tick();

    // 1: nominal frame; stop sampled 76 cycles after rx_s falls, plus sync and detect edges.
    clear_mon();
    start_cyc = cyc;
    send_frame(8'hA5, 1'b1, 1'b0);
    drive(1'b1, 5);
    check("t1_count", got.size(), 1);
    check("t1_data", got_at(0), 8'hA5);
    lat = last_acc_cyc - start_cyc;
    check("t1_latency_in_window", (lat >= 76 + SYNC && lat <= 78 + SYNC), 1'b1);
    check("t1_frame_error", fe_cnt, 0);
    check("t1_overrun", ov_cnt, 0);

    // 2: glitch shorter than half a bit is rejected.
    clear_mon();
    drive(1'b0, 2);
    drive(1'b1, 6);
    check("t2_busy_seen", busy_seen, 1'b1);
    check("t2_busy_low", busy, 1'b0);
    check("t2_no_byte", got.size(), 0);
    check("t2_no_ferr", fe_cnt, 0);

    // 3: low stop bit followed by a long break, then a clean frame.
    clear_mon();
    send_frame(8'h3C, 1'b0, 1'b0);
    drive(1'b0, 30);
    drive(1'b1, 12);
    check("t3_one_ferr", fe_cnt, 1);
    check("t3_no_byte", got.size(), 0);
    check("t3_rx_valid", rx_valid, 1'b0);
    clear_mon();
    send_frame(8'h55, 1'b1, 1'b0);
    drive(1'b1, 5);
    check("t3_next_count", got.size(), 1);
    check("t3_next_data", got_at(0), 8'h55);
    check("t3_next_ferr", fe_cnt, 0);

    // 4a: holding register full and not read -> second byte dropped with overrun.
    clear_mon();
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    drive(1'b1, 5);
    check("t4a_valid", rx_valid, 1'b1);
    check("t4a_data", rx_data, 8'h11);
    check("t4a_overrun", ov_cnt, 1);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    check("t4a_cleared", rx_valid, 1'b0);
    check("t4a_accepted", got_at(0), 8'h11);

    // 4b: read coincides with the delivery edge of the second byte (79 edges after its start).
    clear_mon();
    send_frame(8'h11, 1'b1, 1'b0);
    fork
      send_frame(8'h22, 1'b1, 1'b0);
      begin
        repeat (78) tick();
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
      end
    join
    drive(1'b1, 5);
    check("t4b_valid", rx_valid, 1'b1);
    check("t4b_data", rx_data, 8'h22);
    check("t4b_overrun", ov_cnt, 0);
    check("t4b_first_read", got_at(0), 8'h11);
    rx_ready = 1'b1;
    tick();
    check("t4b_second_read", got_at(1), 8'h22);

    // 5: reset while data bit 4 of 8'hF0 is being received.
    clear_mon();
    fork
      send_frame(8'hF0, 1'b1, 1'b0);
      begin
        repeat (44) tick();
        check("t5_busy_before", busy, 1'b1);
        reset = 1'b1;
        repeat (2) tick();
        check_reset_outputs("t5_reset");
        reset = 1'b0;
      end
    join
    drive(1'b1, 10);
    check("t5_no_byte", got.size(), 0);
    check("t5_no_ferr", fe_cnt, 0);
    clear_mon();
    send_frame(8'h0F, 1'b1, 1'b0);
    drive(1'b1, 5);
    check("t5_next_data", got_at(0), 8'h0F);
    check("t5_next_ferr", fe_cnt, 0);

    // 6: 16 random bytes back-to-back with 7/8/9-cycle bits.
    clear_mon();
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      send_frame(b, 1'b1, 1'b1);
    end
    drive(1'b1, 6);
    check("t6_count", got.size(), exp_q.size());
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t6_byte%0d", i), got_at(i), {24'h0, exp_q[i]});
    end
    check("t6_ferr", fe_cnt, 0);
    check("t6_overrun", ov_cnt, 0);
    check("never_both_pulses", both_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
